// File: rtl/vram_write_scheduler.sv
// Shared address-port scheduler for screen_ram/color_ram: scanout first, then queued host writes or a clear-screen fill.
// Optional build macro VRAM_GUARD_EN: out-of-range host writes are dropped and flagged on wr_err.
module vram_write_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLS       = 80,
  parameter int ROWS       = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_active,
  input  logic [11:0] disp_addr,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_char,
  input  logic [7:0]  wr_colr,
  input  logic [1:0]  wr_be,
  input  logic        clr_start,
  input  logic [7:0]  clr_char,
  input  logic [7:0]  clr_colr,
  output logic        busy,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_char_d,
  output logic [7:0]  ram_colr_d,
  output logic        wren_char,
  output logic        wren_colr,
  output logic        wr_err,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [6:0] COLS_L = 7'(COLS);
  localparam logic [4:0] ROWS_L = 5'(ROWS);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLEAR_WAIT = 2'd1,
    ST_CLEAR      = 2'd2
  } state_e;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  chr;
    logic [7:0]  colr;
    logic [1:0]  be;
  } entry_t;

  state_e      state_q, state_d;
  entry_t      fifo_q [FIFO_DEPTH];
  entry_t      head;
  logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        ready_en_q;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [7:0]  fill_char_q, fill_char_d, fill_colr_q, fill_colr_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  char_q, char_d, colr_q, colr_d;
  logic        wren_char_q, wren_char_d, wren_colr_q, wren_colr_d;
  logic        empty, full, push, pop;

  // Handshake: a write is accepted on any edge where wr_valid and wr_ready are both high;
  // wr_ready depends only on registered state, never on wr_valid.
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign wr_ready = ready_en_q && !full && (state_q == ST_IDLE);
  assign push     = wr_valid && wr_ready;
  assign head     = fifo_q[rptr_q[PW-1:0]];
  assign wptr_d   = wptr_q + {{PW{1'b0}}, push};
  assign rptr_d   = rptr_q + {{PW{1'b0}}, pop};

`ifdef VRAM_GUARD_EN
  logic err_q, err_d;
  logic entry_bad;
  assign entry_bad = (head.addr[6:0] >= COLS_L) || (head.addr[11:7] >= ROWS_L);
  assign wr_err    = err_q;
`else
  assign wr_err    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    fill_char_d = fill_char_q;
    fill_colr_d = fill_colr_q;
    addr_d      = addr_q;
    char_d      = char_q;
    colr_d      = colr_q;
    wren_char_d = 1'b0;
    wren_colr_d = 1'b0;
    pop         = 1'b0;
`ifdef VRAM_GUARD_EN
    err_d       = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (clr_start && ready_en_q) begin
          state_d     = ST_CLEAR_WAIT;
          fill_char_d = clr_char;
          fill_colr_d = clr_colr;
        end
      end
      ST_CLEAR_WAIT: begin
        if (empty) begin
          state_d = ST_CLEAR;
          row_d   = '0;
          col_d   = '0;
        end
      end
      default: ;
    endcase

    // Port slot arbitration: scanout, then clear, then queued host writes.
    if (disp_active) begin
      addr_d = disp_addr;
    end else if (state_q == ST_CLEAR) begin
      addr_d      = {row_q, col_q};
      char_d      = fill_char_q;
      colr_d      = fill_colr_q;
      wren_char_d = 1'b1;
      wren_colr_d = 1'b1;
      if (col_q == COLS_L - 7'd1) begin
        col_d = '0;
        row_d = row_q + 5'd1;
        if (row_q == ROWS_L - 5'd1) state_d = ST_IDLE;
      end else begin
        col_d = col_q + 7'd1;
      end
    end else if (!empty) begin
      pop = 1'b1;
`ifdef VRAM_GUARD_EN
      if (entry_bad) err_d = 1'b1;
      else
`endif
      begin
        addr_d      = head.addr;
        char_d      = head.chr;
        colr_d      = head.colr;
        wren_char_d = head.be[0];
        wren_colr_d = head.be[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[PW-1:0]] <= '{addr: wr_addr, chr: wr_char, colr: wr_colr, be: wr_be};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ready_en_q  <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      fill_char_q <= '0;
      fill_colr_q <= '0;
      addr_q      <= '0;
      char_q      <= '0;
      colr_q      <= '0;
      wren_char_q <= 1'b0;
      wren_colr_q <= 1'b0;
`ifdef VRAM_GUARD_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ready_en_q  <= 1'b1;
      row_q       <= row_d;
      col_q       <= col_d;
      fill_char_q <= fill_char_d;
      fill_colr_q <= fill_colr_d;
      addr_q      <= addr_d;
      char_q      <= char_d;
      colr_q      <= colr_d;
      wren_char_q <= wren_char_d;
      wren_colr_q <= wren_colr_d;
`ifdef VRAM_GUARD_EN
      err_q       <= err_d;
`endif
    end
  end

  assign busy       = !empty || (state_q != ST_IDLE);
  assign ram_addr   = addr_q;
  assign ram_char_d = char_q;
  assign ram_colr_d = colr_q;
  assign wren_char  = wren_char_q;
  assign wren_colr  = wren_colr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Randomized + directed bench for vram_write_scheduler against a queue-based reference model.
module tb_vram_write_scheduler;

  localparam int FIFO_DEPTH = 4;
  localparam int COLS = 80;
  localparam int ROWS = 25;
`ifdef VRAM_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_active = 1'b0;
  logic [11:0] disp_addr = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [11:0] wr_addr = '0;
  logic [7:0]  wr_char = '0, wr_colr = '0;
  logic [1:0]  wr_be = '0;
  logic        clr_start = 1'b0;
  logic [7:0]  clr_char = '0, clr_colr = '0;
  logic        busy;
  logic [11:0] ram_addr;
  logic [7:0]  ram_char_d, ram_colr_d;
  logic        wren_char, wren_colr, wr_err;
  logic [1:0]  dbg_state;

  vram_write_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .disp_active(disp_active), .disp_addr(disp_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_char(wr_char),
    .wr_colr(wr_colr), .wr_be(wr_be), .clr_start(clr_start), .clr_char(clr_char),
    .clr_colr(clr_colr), .busy(busy), .ram_addr(ram_addr), .ram_char_d(ram_char_d),
    .ram_colr_d(ram_colr_d), .wren_char(wren_char), .wren_colr(wren_colr),
    .wr_err(wr_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: pending host writes as {addr,char,colr,be}, plus clear progress
  logic [29:0] exp_q[$];
  int          m_mode;      // 0 idle, 1 clear requested, 2 clearing
  int          m_idx;       // linear cell index of next clear write
  logic [7:0]  m_fc, m_fk;
  logic        m_ready_en;
  logic [11:0] e_addr;
  logic [7:0]  e_char, e_colr;
  logic        e_wc, e_wk, e_err;

  task automatic model_reset();
    exp_q.delete();
    m_mode = 0; m_idx = 0; m_fc = '0; m_fk = '0; m_ready_en = 1'b0;
    e_addr = '0; e_char = '0; e_colr = '0; e_wc = 1'b0; e_wk = 1'b0; e_err = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_addr"}, 32'(ram_addr), 32'h0);
    check({pfx, "_char"}, 32'(ram_char_d), 32'h0);
    check({pfx, "_colr"}, 32'(ram_colr_d), 32'h0);
    check({pfx, "_wren"}, {30'b0, wren_char, wren_colr}, 32'h0);
    check({pfx, "_err"}, 32'(wr_err), 32'h0);
    check({pfx, "_ready"}, 32'(wr_ready), 32'h0);
    check({pfx, "_busy"}, 32'(busy), 32'h0);
    check({pfx, "_state"}, 32'(dbg_state), 32'h0);
  endtask

  // asserts reset immediately, holds it, releases on a falling edge
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready_lo", 32'(wr_ready), 32'h0);
    @(posedge clk);
    #1;
    m_ready_en = 1'b1;
    check("rel_ready_hi", 32'(wr_ready), 32'h1);
    check("rel_wren", {30'b0, wren_char, wren_colr}, 32'h0);
  endtask

  // driver: one clock cycle of stimulus, model update and output comparison
  task automatic cycle(input logic da, input logic [11:0] dad, input logic wv,
                       input logic [29:0] w, input logic cs,
                       input logic [7:0] cc, input logic [7:0] ccl);
    logic        exp_ready, push, was_empty;
    logic [29:0] h;
    int          nxt_mode;
    @(negedge clk);
    disp_active = da; disp_addr = dad; wr_valid = wv;
    {wr_addr, wr_char, wr_colr, wr_be} = w;
    clr_start = cs; clr_char = cc; clr_colr = ccl;
    exp_ready = m_ready_en && (exp_q.size() < FIFO_DEPTH) && (m_mode == 0);
    #1;
    check("wr_ready", 32'(wr_ready), 32'(exp_ready));
    push      = wv && exp_ready;
    was_empty = (exp_q.size() == 0);
    nxt_mode  = m_mode;
    e_wc = 1'b0; e_wk = 1'b0; e_err = 1'b0;
    if (m_mode == 0 && cs && m_ready_en) begin
      nxt_mode = 1; m_fc = cc; m_fk = ccl;
    end
    if (m_mode == 1 && was_empty) begin
      nxt_mode = 2; m_idx = 0;
    end
    if (da) begin
      e_addr = dad;
    end else if (m_mode == 2) begin
      e_addr = {5'(m_idx / COLS), 7'(m_idx % COLS)};
      e_char = m_fc; e_colr = m_fk; e_wc = 1'b1; e_wk = 1'b1;
      m_idx++;
      if (m_idx == ROWS * COLS) nxt_mode = 0;
    end else if (!was_empty) begin
      h = exp_q.pop_front();
      if (GUARD && (int'(h[29:25]) >= ROWS || int'(h[24:18]) >= COLS)) begin
        e_err = 1'b1;
      end else begin
        e_addr = h[29:18]; e_char = h[17:10]; e_colr = h[9:2];
        e_wc = h[0]; e_wk = h[1];
      end
    end
    if (push) exp_q.push_back(w);
    m_mode = nxt_mode;
    @(posedge clk);
    #1;
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("wren_char", 32'(wren_char), 32'(e_wc));
    check("wren_colr", 32'(wren_colr), 32'(e_wk));
    if (e_wc) check("ram_char", 32'(ram_char_d), 32'(e_char));
    if (e_wk) check("ram_colr", 32'(ram_colr_d), 32'(e_colr));
    check("wr_err", 32'(wr_err), 32'(e_err));
    check("busy", 32'(busy), 32'((exp_q.size() != 0) || (m_mode != 0)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 12'h0, 1'b0, 30'h0, 1'b0, 8'h0, 8'h0);
  endtask

  task automatic drain(input string tag, input int bound);
    int c;
    c = 0;
    while (busy && c < bound) begin
      cycle(1'b0, 12'h0, 1'b0, 30'h0, 1'b0, 8'h0, 8'h0);
      c++;
    end
    check({tag, "_drain_timeout"}, 32'(busy), 32'h0);
  endtask

  // runs a clear to completion; toggle=1 alternates scanout slots
  task automatic run_clear(input string tag, input logic toggle, input int bound,
                           input logic [7:0] fc, input logic [7:0] fk);
    int          c, writes;
    logic [11:0] last;
    logic        da;
    writes = 0; last = '0; c = 0;
    cycle(1'b0, 12'h0, 1'b0, 30'h0, 1'b1, fc, fk);
    while (busy && c < bound) begin
      da = toggle ? logic'(c % 2) : 1'b0;
      cycle(da, 12'($urandom_range(0, 4095)), 1'b0, 30'h0, 1'b0, 8'h0, 8'h0);
      if (wren_char && wren_colr && ram_char_d == fc && ram_colr_d == fk) begin
        writes++;
        last = ram_addr;
      end
      c++;
    end
    check({tag, "_timeout"}, 32'(busy), 32'h0);
    check({tag, "_count"}, 32'(writes), 32'(ROWS * COLS));
    check({tag, "_last"}, 32'(last), 32'hC4F);
  endtask

  initial begin
    rst_n = 1'b1;
    #2;
    do_reset();

    // single write, both enables
    cycle(1'b0, 12'h0, 1'b1, {12'h005, 8'h41, 8'h1F, 2'b11}, 1'b0, 8'h0, 8'h0);
    idle(2);

    // scanout holds the port while the queue fills, then drains in order
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 12'(12'h200 + i), 1'b1, {12'(12'h010 + i), 8'(8'h30 + i), 8'(8'h60 + i), 2'b11},
            1'b0, 8'h0, 8'h0);
    idle(5);

    // byte enables to the same cell
    cycle(1'b0, 12'h0, 1'b1, {12'h081, 8'h55, 8'hAA, 2'b01}, 1'b0, 8'h0, 8'h0);
    cycle(1'b0, 12'h0, 1'b1, {12'h081, 8'h66, 8'hBB, 2'b10}, 1'b0, 8'h0, 8'h0);
    idle(3);

    // out-of-range column
    cycle(1'b0, 12'h0, 1'b1, {12'h050, 8'h58, 8'h2A, 2'b11}, 1'b0, 8'h0, 8'h0);
    idle(3);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [11:0] a;
      a = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095))
                                      : {5'($urandom_range(0, ROWS - 1)), 7'($urandom_range(0, COLS - 1))};
      cycle(logic'($urandom_range(0, 2) == 0), 12'($urandom_range(0, 4095)),
            logic'($urandom_range(0, 1)),
            {a, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
            1'b0, 8'h0, 8'h0);
    end
    drain("rand", 40);

    // two queued writes ahead of a clear
    cycle(1'b1, 12'h300, 1'b1, {12'h100, 8'h41, 8'h11, 2'b11}, 1'b0, 8'h0, 8'h0);
    cycle(1'b1, 12'h301, 1'b1, {12'h101, 8'h42, 8'h12, 2'b11}, 1'b0, 8'h0, 8'h0);
    run_clear("clr", 1'b0, 2200, 8'h20, 8'h07);
    idle(2);

    // clear interleaved with scanout
    run_clear("clr_tog", 1'b1, 4200, 8'h2E, 8'h1C);
    idle(2);

    // reset in the middle of a clear
    cycle(1'b0, 12'h0, 1'b0, 30'h0, 1'b1, 8'h23, 8'h4E);
    idle(50);
    #2;
    do_reset();
    idle(4);
    cycle(1'b0, 12'h0, 1'b1, {12'h0C4, 8'h7A, 8'h3C, 2'b11}, 1'b0, 8'h0, 8'h0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
